// File: rtl/vector_div_sequencer.sv
// vector_div_sequencer: walks one vector divide/remainder op from vstart to vl-1,
// resolves masked, divide-by-zero and signed-overflow elements locally, and hands
// every other element to the lane divider through a start_div / busy_du handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | op_ready high, waiting for op_valid
// ISSUE  | classify element idx; skip, bypass, or start the divider
// WAIT   | divider running; operands held; capture on first busy_du=0
// DONE   | one-cycle op_done pulse
// FLUSH  | aborted while divider busy; drain it and drop its result
module vector_div_sequencer #(
    parameter int MAX_VL = 32,
    parameter int IDX_W  = $clog2(MAX_VL) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [IDX_W-1:0] op_vl,
    input  logic [IDX_W-1:0] op_vstart,
    input  logic             op_vm,
    input  logic             op_signed,
    input  logic             op_div_type,
    input  logic             flush,
    output logic [IDX_W-1:0] elem_idx,
    input  logic [31:0]      vs1_elem,
    input  logic [31:0]      vs2_elem,
    input  logic             mask_bit,
    output logic             start_div,
    output logic [31:0]      vs1_data,
    output logic [31:0]      vs2_data,
    output logic             is_signed_div,
    output logic             div_type,
    input  logic             busy_du,
    input  logic [31:0]      wdata_du,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_data,
    output logic             op_done,
    output logic             dbz_flag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] vl_q, vl_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vm_q, vm_d;
    logic             signed_q, signed_d;
    logic             div_type_q, div_type_d;
    logic             dbz_q, dbz_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic             accept;
    logic             masked;
    logic             is_dbz;
    logic             is_ovf;
    logic             bypass;
    logic             need_div;
    logic             last;
    logic [IDX_W-1:0] idx_inc;
    logic [31:0]      bypass_data;

    // Element classification for the element currently addressed in ISSUE.
    always_comb begin
        accept   = (state_q == S_IDLE) && op_valid && !flush;
        masked   = !vm_q && !mask_bit;
        is_dbz   = (vs1_elem == 32'h0000_0000);
        is_ovf   = signed_q && (vs2_elem == 32'h8000_0000) && (vs1_elem == 32'hFFFF_FFFF);
        bypass   = !masked && (is_dbz || is_ovf);
        need_div = !masked && !bypass;
        idx_inc  = idx_q + IDX_W'(1);
        last     = (idx_inc == vl_q);
        if (is_dbz) begin
            bypass_data = div_type_q ? 32'hFFFF_FFFF : vs2_elem;
        end else begin
            bypass_data = div_type_q ? 32'h8000_0000 : 32'h0000_0000;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a divider start is held off while busy_du is still high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op_vstart >= op_vl) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (need_div) begin
                    if (!busy_du) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = last ? S_DONE : S_ISSUE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (!busy_du) begin
                    state_d = last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FLUSH: begin
                if (!busy_du) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Op context, element index, operand capture and writeback staging.
    always_comb begin
        vl_d       = vl_q;
        idx_d      = idx_q;
        vm_d       = vm_q;
        signed_d   = signed_q;
        div_type_d = div_type_q;
        dbz_d      = dbz_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        wb_valid_d = 1'b0;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vl_d       = op_vl;
                    idx_d      = op_vstart;
                    vm_d       = op_vm;
                    signed_d   = op_signed;
                    div_type_d = op_div_type;
                    dbz_d      = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!flush) begin
                    if (masked) begin
                        idx_d = idx_inc;
                    end else if (bypass) begin
                        wb_valid_d = 1'b1;
                        wb_idx_d   = idx_q;
                        wb_data_d  = bypass_data;
                        dbz_d      = dbz_q | is_dbz;
                        idx_d      = idx_inc;
                    end else if (!busy_du) begin
                        opa_d = vs1_elem;
                        opb_d = vs2_elem;
                    end
                end
            end
            S_WAIT: begin
                if (!flush && !busy_du) begin
                    wb_valid_d = 1'b1;
                    wb_idx_d   = idx_q;
                    wb_data_d  = wdata_du;
                    idx_d      = idx_inc;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vl_q       <= '0;
            idx_q      <= '0;
            vm_q       <= 1'b0;
            signed_q   <= 1'b0;
            div_type_q <= 1'b0;
            dbz_q      <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            vl_q       <= vl_d;
            idx_q      <= idx_d;
            vm_q       <= vm_d;
            signed_q   <= signed_d;
            div_type_q <= div_type_d;
            dbz_q      <= dbz_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Outputs; operands pass straight through in ISSUE so start_div needs no extra cycle.
    always_comb begin
        op_ready      = (state_q == S_IDLE);
        start_div     = (state_q == S_ISSUE) && need_div && !flush && !busy_du;
        op_done       = (state_q == S_DONE) && !flush;
        elem_idx      = idx_q;
        vs1_data      = (state_q == S_ISSUE) ? vs1_elem : opa_q;
        vs2_data      = (state_q == S_ISSUE) ? vs2_elem : opb_q;
        is_signed_div = signed_q;
        div_type      = div_type_q;
        wb_valid      = wb_valid_q;
        wb_idx        = wb_idx_q;
        wb_data       = wb_data_q;
        dbz_flag      = dbz_q;
    end

endmodule

// File: doc/vector_div_sequencer.md
# vector_div_sequencer

Per-lane element sequencer that sits directly upstream of the lane divide unit. It accepts one vector divide/remainder operation (vstart..vl-1), reads element operands, and handles masked-off elements and RISC-V special cases (divide-by-zero, signed overflow) locally. All remaining elements are issued to the divider one at a time via a start pulse / busy handshake. Each result goes out on a registered writeback port, and the block signals operation completion.

## Interface
Parameters
- MAX_VL, 32: maximum vector length (elements per op). Element width is fixed at 32 bits.
- IDX_W, $clog2(MAX_VL)+1: element index / vl width (derived; do not override).

Ports
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- op_valid  in  1  new op request.
- op_ready  out  1  high in IDLE only.
- op_vl  in  IDX_W  vector length.
- op_vstart  in  IDX_W  first element index.
- op_vm  in  1  1 = unmasked; 0 = use mask_bit.
- op_signed  in  1  signed divide.
- op_div_type  in  1  1 = quotient, 0 = remainder.
- flush  in  1  synchronous abort.
- elem_idx  out  IDX_W-1..0  operand read index (combinational read).
- vs1_elem, vs2_elem  in  32  divisor / dividend of elem_idx.
- mask_bit  in  1  mask of elem_idx.
- start_div  out  1  one-cycle divider start.
- vs1_data, vs2_data  out  32  divider operands.
- is_signed_div, div_type  out  1  latched op_signed / op_div_type.
- busy_du  in  1  divider busy.
- wdata_du  in  32  divider result (quotient or remainder per div_type).
- wb_valid  out  1  registered writeback strobe.
- wb_idx  out  IDX_W-1..0  writeback element index.
- wb_data  out  32  writeback data.
- op_done  out  1  one-cycle completion pulse.
- dbz_flag  out  1  op hit ≥1 divide-by-zero element; valid with op_done, held until next accept.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, FLUSH.
- IDLE: op_ready=1. On op_valid, latch vl, vstart, vm, signed, div_type; clear dbz_flag; idx ← vstart.
  - Go to DONE if vstart ≥ vl (includes vl=0).
  - Otherwise go to ISSUE.
- ISSUE (one cycle per element): elem_idx=idx. Classify:
  - Masked: vm=0 and mask_bit=0. No writeback; idx++.
  - Divide-by-zero: vs1_elem=0.
    - Quotient = 0xFFFFFFFF; remainder = vs2_elem.
    - Set dbz_flag; writeback; idx++.
  - Signed overflow: signed, vs2=0x80000000, vs1=0xFFFFFFFF.
    - Quotient = 0x80000000; remainder = 0.
    - Writeback; idx++.
  - Otherwise:
    - Assert start_div with vs1/vs2_data = vs1_elem/vs2_elem (combinational).
    - Latch both into operand regs; go to WAIT.
  - After masked or bypassed elements: go to DONE if idx+1 = vl, else stay in ISSUE.
- WAIT: vs1/vs2_data driven from operand regs; held stable until result is captured.
  - The first cycle with busy_du=0 is the completion cycle: capture wdata_du for writeback; idx++.
  - Then go to ISSUE, or to DONE if idx+1 = vl.
- DONE: op_done=1 for one cycle, then IDLE.
- flush:
  - In ISSUE or DONE: go to IDLE next cycle; no op_done, no further writebacks.
  - In WAIT: go to FLUSH. FLUSH waits for busy_du=0, discards the result, then goes to IDLE.
  - flush in IDLE: ignored; it also blocks accept that cycle.
- Divider is never started while busy_du=1 or in FLUSH.
- Unsigned mode never bypasses on overflow.

## Timing
- Reset values:
  - Outputs: op_ready=1 (IDLE). start_div, wb_valid, op_done, dbz_flag, wb_idx, wb_data, elem_idx, vs1_data, vs2_data, is_signed_div, div_type = 0.
  - State: IDLE.
- Reset mid-op: immediate return to IDLE; in-flight result dropped.
- Accept at edge T: ISSUE at T+1.
- Masked element: 1 cycle, no writeback.
- Bypassed element: decided in ISSUE cycle t; wb_valid at t+1.
- Divider element: start_div in cycle t; WAIT from t+1. Completion at cycle c (busy_du=0); wb_valid at c+1. The next ISSUE can overlap that writeback cycle.
- op_done asserts in the cycle after the final element's decision/completion. It may coincide with that element's wb_valid.
- At most one wb_valid per element; wb_idx is strictly increasing within an op.

## Test plan
- vl=4, vstart=0, vm=1, unsigned quotient, vs2={100,7,9,0xFFFFFFFF}, vs1={7,2,3,1} → wb {14,3,3,0xFFFFFFFF} at idx 0..3, four start_div pulses, one op_done, dbz_flag=0.
- vl=3, signed remainder, vs1={0,0xFFFFFFFF,5}, vs2={42,0x80000000,-17} → wb idx0=42 (no start_div), idx1=0 (no start_div), idx2=-2 (0xFFFFFFFE) via divider; dbz_flag=1.
- vl=4, vm=0, mask={1,0,0,1} → wb only at idx 0 and 3; exactly two start_div pulses.
- vstart=5, vl=5 and vl=0 → op_done the cycle after accept, no start_div, no wb_valid.
- flush asserted in WAIT while busy_du=1 for 3 more cycles → no wb_valid, no op_done; op_ready returns the cycle after busy_du falls.
- Divider latency 1 for two consecutive elements, then nRST pulse mid-WAIT → all outputs return to reset values immediately; op_ready=1 after release.
